// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the RV32I core.
// Holds the fetch PC, drives a synchronous-read instruction memory and tracks
// whether the word arriving from memory is a real instruction (IF/ID boundary).
// Optional macro FETCH_CNT_EN adds a 32-bit delivered-instruction counter;
// without it fetch_cnt_o is tied to zero.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IMEM_AW  = 10
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [31:0]        target_i,
   output logic               imem_en_o,
   output logic [IMEM_AW-1:0] imem_addr_o,
   input  logic [31:0]        imem_rdata_i,
   output logic [31:0]        instr_o,
   output logic [6:0]         opcode_o,
   output logic [31:0]        pc_o,
   output logic               valid_o,
   output logic [31:0]        fetch_cnt_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc_f;   // address being issued to memory this cycle
   logic [31:0] pc_d;   // PC of the word now on imem_rdata_i
   logic        v_d;    // imem_rdata_i holds a real instruction

   // PC and valid tracking: reset > redirect > stall > run
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pc_f <= RESET_PC;
         pc_d <= RESET_PC;
         v_d  <= 1'b0;
      end else if (redirect_i) begin
         // The word returned next cycle belongs to the old path: squash it
         pc_f <= target_i & ~32'h3;
         v_d  <= 1'b0;
      end else if (!stall_i) begin
         pc_d <= pc_f;
         v_d  <= 1'b1;
         pc_f <= pc_f + 32'd4;
      end
   end

   // Memory holds its output register while stalled, keeping instr_o stable
   assign imem_en_o   = ~stall_i | redirect_i;
   assign imem_addr_o = pc_f[IMEM_AW+1:2];

   // Outputs depend only on state and memory data, never on stall/redirect
   assign instr_o  = v_d ? imem_rdata_i : NOP;
   assign opcode_o = instr_o[6:0];
   assign pc_o     = pc_d;
   assign valid_o  = v_d;

`ifdef FETCH_CNT_EN
   logic [31:0] fetch_cnt;

   // Count instructions actually handed to decode (valid and not held/squashed)
   always_ff @(posedge CLK) begin
      if (RESET) begin
         fetch_cnt <= 32'd0;
      end else if (v_d && !stall_i && !redirect_i) begin
         fetch_cnt <= fetch_cnt + 32'd1;
      end
   end

   assign fetch_cnt_o = fetch_cnt;
`else
   assign fetch_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage.
// The driver issues stall/redirect/reset stimulus and keeps a queue of the PCs
// (and memory words) decode should receive, in program order from the last
// reset/redirect point. The monitor checks outputs on the falling edge and pops
// an entry each time an instruction is handed to decode.
module tb_fetch_stage;

   localparam int unsigned IMEM_AW = 10;
   localparam logic [31:0] RST_PC  = 32'hFFFF_FFF8;  // boot right below the wrap point
   localparam logic [31:0] NOP     = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic               clk;
   logic               rst;
   logic               stall;
   logic               redirect;
   logic [31:0]        target;
   logic               imem_en;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic [31:0]        instr;
   logic [6:0]         opcode;
   logic [31:0]        pc;
   logic               valid;
   logic [31:0]        fetch_cnt;

   logic [31:0] mem [1 << IMEM_AW];

   exp_t        exp_q[$];
   logic [31:0] next_pc;
   logic        restart;
   logic [31:0] restart_pc;

   int          n_checks;
   int          n_fail;

   fetch_stage #(
      .RESET_PC (RST_PC),
      .IMEM_AW  (IMEM_AW)
   ) dut (
      .CLK          (clk),
      .RESET        (rst),
      .stall_i      (stall),
      .redirect_i   (redirect),
      .target_i     (target),
      .imem_en_o    (imem_en),
      .imem_addr_o  (imem_addr),
      .imem_rdata_i (imem_rdata),
      .instr_o      (instr),
      .opcode_o     (opcode),
      .pc_o         (pc),
      .valid_o      (valid),
      .fetch_cnt_o  (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory whose output register holds when not enabled
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; refreshes the expected stream after reset/redirect
   task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] tg);
      @(posedge clk);
      #1;
      if (restart) begin
         exp_q.delete();
         next_pc = restart_pc;
         restart = 1'b0;
      end
      while (exp_q.size() < 4) begin
         exp_q.push_back('{pc: next_pc, instr: mem[next_pc[IMEM_AW+1:2]]});
         next_pc = next_pc + 32'd4;
      end
      rst      = r;
      stall    = s;
      redirect = rd;
      target   = tg;
      if (r) begin
         restart    = 1'b1;
         restart_pc = RST_PC;
      end else if (rd) begin
         restart    = 1'b1;
         restart_pc = tg & ~32'h3;
      end
   endtask

   // Monitor: expected valid/issue address/count follow the stage's cycle rules
   initial begin
      logic        exp_valid;
      logic [31:0] exp_issue;
      logic [31:0] exp_cnt;
      exp_t        e;
      exp_valid = 1'b0;
      exp_issue = RST_PC;
      exp_cnt   = 32'd0;
      forever begin
         @(negedge clk);
         check("valid_o", {31'd0, valid}, {31'd0, exp_valid});
         check("imem_en_o", {31'd0, imem_en}, {31'd0, ~stall | redirect});
         check("imem_addr_o", {22'd0, imem_addr}, {22'd0, exp_issue[IMEM_AW+1:2]});
         check("fetch_cnt_o", fetch_cnt, exp_cnt);
         if (exp_valid) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
               e = exp_q[0];
               check("pc_o", pc, e.pc);
               check("instr_o", instr, e.instr);
               check("opcode_o", {25'd0, opcode}, {25'd0, e.instr[6:0]});
               if (!stall && !redirect && !rst) begin
                  void'(exp_q.pop_front());
`ifdef FETCH_CNT_EN
                  exp_cnt = exp_cnt + 32'd1;
`endif
               end
            end
         end else begin
            check("instr_o_nop", instr, NOP);
            check("opcode_o_nop", {25'd0, opcode}, 32'h13);
         end
         if (rst) begin
            exp_valid = 1'b0;
            exp_issue = RST_PC;
            exp_cnt   = 32'd0;
         end else if (redirect) begin
            exp_valid = 1'b0;
            exp_issue = target & ~32'h3;
         end else if (!stall) begin
            exp_valid = 1'b1;
            exp_issue = exp_issue + 32'd4;
         end
      end
   end

   // Stimulus: directed boot/stall/redirect sequence, then random traffic
   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      stall      = 1'b0;
      redirect   = 1'b0;
      target     = 32'd0;
      restart    = 1'b1;
      restart_pc = RST_PC;
      next_pc    = RST_PC;
      for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = $urandom;

      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);   // boot and wrap
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 32'd0);   // hold
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0043);                       // redirect wins over stall
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0040);
      drive(1'b0, 1'b1, 1'b0, 32'd0);                               // stall inside the bubble
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);
      drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);                       // redirect onto the wrap
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h0000_1234);                       // reset beats both
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         logic        r;
         logic        s;
         logic        rd;
         logic [31:0] tg;
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 25);
         rd = ($urandom_range(0, 99) < 8);
         tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : $urandom;
         drive(r, s, rd, tg);
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
